// File: rtl/game_round_sequencer.sv
// game_round_sequencer: whack-a-mole round controller.
// Handles start detection, countdown, timed play with pause, the 1 Hz time base and the BCD seconds display.
module game_round_sequencer #(
   parameter int TICKS_PER_SEC     = 50000000,
   parameter int COUNTDOWN_SECONDS = 3,
   parameter int ROUND_SECONDS     = 30
) (
   input  logic       ClockIn,
   input  logic       Reset,
   input  logic       start,
   input  logic       pause,
   output logic [2:0] state,
   output logic       sec_tick,
   output logic [3:0] countdown_bcd,
   output logic [3:0] secs_tens,
   output logic [3:0] secs_ones,
   output logic       mole_enable,
   output logic       timer_clear,
   output logic       round_done,
   output logic       done_pulse
);
   localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
   localparam logic [3:0] CD_INIT = 4'(COUNTDOWN_SECONDS);
   localparam logic [3:0] TENS_INIT = 4'(ROUND_SECONDS / 10);
   localparam logic [3:0] ONES_INIT = 4'(ROUND_SECONDS % 10);

   typedef enum logic [2:0] {IDLE = 3'd0, COUNTDOWN = 3'd1, PLAY = 3'd2, PAUSED = 3'd3, DONE = 3'd4} state_t;

   state_t cur, nxt;
   logic [PW-1:0] presc;
   logic start_q, pause_q, armed;
   logic start_rise, pause_rise, running, tick, enter_cd, leave_cd, last_sec;

   // armed masks edges on the first cycle after reset, so a button held through reset is not seen as a press
   assign start_rise = armed & start & ~start_q;
   assign pause_rise = armed & pause & ~pause_q;
   assign running    = (cur == COUNTDOWN) || (cur == PLAY);
   assign tick       = running && (presc == PMAX);
   assign enter_cd   = ((cur == IDLE) || (cur == DONE)) && start_rise;
   assign leave_cd   = (cur == COUNTDOWN) && (nxt == PLAY);
   assign last_sec   = (secs_tens == 4'd0) && (secs_ones == 4'd1);

   always_ff @(posedge ClockIn) begin
      if (Reset)
         cur <= IDLE;
      else
         cur <= nxt;
   end

   always_comb begin
      nxt = cur;
      case (cur)
         IDLE, DONE: nxt = start_rise ? COUNTDOWN : cur;
         COUNTDOWN:  nxt = ((countdown_bcd == 4'd0) || (tick && countdown_bcd == 4'd1)) ? PLAY : COUNTDOWN;
         PLAY:       nxt = (tick && last_sec) ? DONE : (pause_rise ? PAUSED : PLAY);
         PAUSED:     nxt = pause_rise ? PLAY : PAUSED;
         default:    nxt = IDLE;
      endcase
   end

   always_comb begin
      state       = cur;
      sec_tick    = tick;
      mole_enable = (cur == PLAY);
      round_done  = (cur == DONE);
   end

   always_ff @(posedge ClockIn) begin
      if (Reset) begin
         start_q       <= 1'b0;
         pause_q       <= 1'b0;
         armed         <= 1'b0;
         presc         <= '0;
         countdown_bcd <= 4'd0;
         secs_tens     <= 4'd0;
         secs_ones     <= 4'd0;
         timer_clear   <= 1'b0;
         done_pulse    <= 1'b0;
      end else begin
         start_q     <= start;
         pause_q     <= pause;
         armed       <= 1'b1;
         timer_clear <= enter_cd;
         done_pulse  <= (cur == PLAY) && tick && last_sec;
         // play always starts on a fresh second, even when the countdown is zero-length
         if ((cur == IDLE) || (cur == DONE) || leave_cd)
            presc <= '0;
         else if (running)
            presc <= tick ? '0 : presc + 1'b1;
         if (enter_cd)
            countdown_bcd <= CD_INIT;
         else if ((cur == COUNTDOWN) && tick && (countdown_bcd != 4'd0))
            countdown_bcd <= countdown_bcd - 4'd1;
         if (enter_cd) begin
            secs_tens <= TENS_INIT;
            secs_ones <= ONES_INIT;
         end else if ((cur == PLAY) && tick && ((secs_tens != 4'd0) || (secs_ones != 4'd0))) begin
            secs_tens <= (secs_ones == 4'd0) ? secs_tens - 4'd1 : secs_tens;
            secs_ones <= (secs_ones == 4'd0) ? 4'd9 : secs_ones - 4'd1;
         end
      end
   end
endmodule

// File: tb/tb_game_round_sequencer.sv
// tb_game_round_sequencer: directed vector table plus hand sequences for the zero-length countdown.
module tb_game_round_sequencer;
   logic ClockIn = 1'b0;
   logic Reset = 1'b1;
   logic start = 1'b0, pause = 1'b0, start1 = 1'b0, pause1 = 1'b0;
   logic [2:0] state, state1;
   logic sec_tick, mole_enable, timer_clear, round_done, done_pulse;
   logic sec_tick1, mole_enable1, timer_clear1, round_done1, done_pulse1;
   logic [3:0] countdown_bcd, secs_tens, secs_ones, countdown_bcd1, secs_tens1, secs_ones1;
   int checks = 0, errors = 0;

   always #5 ClockIn = ~ClockIn;

   game_round_sequencer #(.TICKS_PER_SEC(4), .COUNTDOWN_SECONDS(3), .ROUND_SECONDS(12)) u0 (
      .ClockIn(ClockIn), .Reset(Reset), .start(start), .pause(pause), .state(state),
      .sec_tick(sec_tick), .countdown_bcd(countdown_bcd), .secs_tens(secs_tens), .secs_ones(secs_ones),
      .mole_enable(mole_enable), .timer_clear(timer_clear), .round_done(round_done), .done_pulse(done_pulse));

   game_round_sequencer #(.TICKS_PER_SEC(4), .COUNTDOWN_SECONDS(0), .ROUND_SECONDS(12)) u1 (
      .ClockIn(ClockIn), .Reset(Reset), .start(start1), .pause(pause1), .state(state1),
      .sec_tick(sec_tick1), .countdown_bcd(countdown_bcd1), .secs_tens(secs_tens1), .secs_ones(secs_ones1),
      .mole_enable(mole_enable1), .timer_clear(timer_clear1), .round_done(round_done1), .done_pulse(done_pulse1));

   typedef struct {
      int n;
      logic rst, st, pa;
      logic [2:0] s;
      logic [3:0] cd, tens, ones;
      logic tk, me, tc, rd, dp;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(int n, int rst, int st, int pa, int s, int cd, int tens, int ones,
                               int tk, int me, int tc, int rd, int dp);
      vec_t v;
      v.n = n; v.rst = 1'(rst); v.st = 1'(st); v.pa = 1'(pa);
      v.s = 3'(s); v.cd = 4'(cd); v.tens = 4'(tens); v.ones = 4'(ones);
      v.tk = 1'(tk); v.me = 1'(me); v.tc = 1'(tc); v.rd = 1'(rd); v.dp = 1'(dp);
      return v;
   endfunction

   task automatic chk(input string nm, input int row, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0d expected %0d", nm, row, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge ClockIn);
      #1;
   endtask

   initial begin
      int cyc;
      tv.push_back(mk( 1,0,1,0, 1,3,1,2, 0,0,1,0,0));
      tv.push_back(mk( 1,0,0,0, 1,3,1,2, 0,0,0,0,0));
      tv.push_back(mk( 2,0,0,0, 1,3,1,2, 1,0,0,0,0));
      tv.push_back(mk( 1,0,0,0, 1,2,1,2, 0,0,0,0,0));
      tv.push_back(mk( 4,0,0,0, 1,1,1,2, 0,0,0,0,0));
      tv.push_back(mk( 3,0,0,0, 1,1,1,2, 1,0,0,0,0));
      tv.push_back(mk( 1,0,0,0, 2,0,1,2, 0,1,0,0,0));
      tv.push_back(mk( 3,0,0,0, 2,0,1,2, 1,1,0,0,0));
      tv.push_back(mk( 1,0,0,0, 2,0,1,1, 0,1,0,0,0));
      tv.push_back(mk( 4,0,0,0, 2,0,1,0, 0,1,0,0,0));
      tv.push_back(mk( 4,0,0,0, 2,0,0,9, 0,1,0,0,0));
      tv.push_back(mk( 4,0,0,0, 2,0,0,8, 0,1,0,0,0));
      tv.push_back(mk( 4,0,0,0, 2,0,0,7, 0,1,0,0,0));
      tv.push_back(mk( 1,0,0,0, 2,0,0,7, 0,1,0,0,0));
      tv.push_back(mk( 1,0,0,1, 3,0,0,7, 0,0,0,0,0));
      tv.push_back(mk(20,0,0,0, 3,0,0,7, 0,0,0,0,0));
      tv.push_back(mk( 1,0,0,1, 2,0,0,7, 0,1,0,0,0));
      tv.push_back(mk( 1,0,0,0, 2,0,0,7, 1,1,0,0,0));
      tv.push_back(mk( 1,0,0,0, 2,0,0,6, 0,1,0,0,0));
      tv.push_back(mk( 4,0,0,0, 2,0,0,5, 0,1,0,0,0));
      tv.push_back(mk( 3,0,0,0, 2,0,0,5, 1,1,0,0,0));
      tv.push_back(mk( 1,0,0,1, 3,0,0,4, 0,0,0,0,0));
      tv.push_back(mk( 1,0,0,0, 3,0,0,4, 0,0,0,0,0));
      tv.push_back(mk( 1,0,0,1, 2,0,0,4, 0,1,0,0,0));
      tv.push_back(mk( 4,0,0,0, 2,0,0,3, 0,1,0,0,0));
      tv.push_back(mk( 4,0,0,0, 2,0,0,2, 0,1,0,0,0));
      tv.push_back(mk( 4,0,0,0, 2,0,0,1, 0,1,0,0,0));
      tv.push_back(mk( 3,0,0,0, 2,0,0,1, 1,1,0,0,0));
      tv.push_back(mk( 1,0,0,1, 4,0,0,0, 0,0,0,1,1));
      tv.push_back(mk( 1,0,0,0, 4,0,0,0, 0,0,0,1,0));
      tv.push_back(mk( 1,0,0,1, 4,0,0,0, 0,0,0,1,0));
      tv.push_back(mk( 1,0,0,0, 4,0,0,0, 0,0,0,1,0));
      tv.push_back(mk( 1,0,1,0, 1,3,1,2, 0,0,1,0,0));
      tv.push_back(mk( 1,0,0,0, 1,3,1,2, 0,0,0,0,0));
      tv.push_back(mk(11,0,0,0, 2,0,1,2, 0,1,0,0,0));
      tv.push_back(mk(16,0,0,0, 2,0,0,8, 0,1,0,0,0));
      tv.push_back(mk( 1,0,1,0, 2,0,0,8, 0,1,0,0,0));
      tv.push_back(mk( 1,0,0,0, 2,0,0,8, 0,1,0,0,0));
      tv.push_back(mk( 1,1,1,0, 0,0,0,0, 0,0,0,0,0));
      tv.push_back(mk( 2,1,1,0, 0,0,0,0, 0,0,0,0,0));
      tv.push_back(mk( 3,0,1,0, 0,0,0,0, 0,0,0,0,0));
      tv.push_back(mk( 1,0,0,0, 0,0,0,0, 0,0,0,0,0));
      tv.push_back(mk( 1,0,1,0, 1,3,1,2, 0,0,1,0,0));

      step(2);
      chk("reset_state", -1, 8'(state), 8'd0);
      chk("reset_secs", -1, {secs_tens, secs_ones}, 8'h00);
      chk("reset_u1_state", -1, 8'(state1), 8'd0);
      Reset = 1'b0;
      step(1);

      foreach (tv[i]) begin
         Reset = tv[i].rst; start = tv[i].st; pause = tv[i].pa;
         step(tv[i].n);
         chk("state", i, 8'(state), 8'(tv[i].s));
         chk("countdown_bcd", i, 8'(countdown_bcd), 8'(tv[i].cd));
         chk("secs_tens", i, 8'(secs_tens), 8'(tv[i].tens));
         chk("secs_ones", i, 8'(secs_ones), 8'(tv[i].ones));
         chk("sec_tick", i, 8'(sec_tick), 8'(tv[i].tk));
         chk("mole_enable", i, 8'(mole_enable), 8'(tv[i].me));
         chk("timer_clear", i, 8'(timer_clear), 8'(tv[i].tc));
         chk("round_done", i, 8'(round_done), 8'(tv[i].rd));
         chk("done_pulse", i, 8'(done_pulse), 8'(tv[i].dp));
      end
      start = 1'b0;

      start1 = 1'b1; step(1);
      chk("cd0_enter_state", 100, 8'(state1), 8'd1);
      chk("cd0_enter_clear", 100, 8'(timer_clear1), 8'd1);
      chk("cd0_enter_secs", 100, {secs_tens1, secs_ones1}, 8'h12);
      step(1);
      chk("cd0_play_state", 101, 8'(state1), 8'd2);
      chk("cd0_play_mole", 101, 8'(mole_enable1), 8'd1);
      start1 = 1'b0; step(1);
      start1 = 1'b1; step(1);
      chk("cd0_start_in_play", 102, 8'(state1), 8'd2);
      chk("cd0_start_in_play_secs", 102, {secs_tens1, secs_ones1}, 8'h12);
      start1 = 1'b0;
      cyc = 0;
      while (!round_done1 && cyc < 100) begin
         step(1);
         cyc++;
      end
      chk("cd0_play_length", 103, 8'(cyc), 8'd46);
      chk("cd0_done_state", 103, 8'(state1), 8'd4);
      chk("cd0_done_secs", 103, {secs_tens1, secs_ones1}, 8'h00);
      chk("cd0_done_pulse", 103, 8'(done_pulse1), 8'd1);
      chk("cd0_done_mole", 103, 8'(mole_enable1), 8'd0);
      step(1);
      chk("cd0_done_pulse_end", 104, 8'(done_pulse1), 8'd0);
      start1 = 1'b1; step(1);
      chk("cd0_restart_state", 105, 8'(state1), 8'd1);
      chk("cd0_restart_secs", 105, {secs_tens1, secs_ones1}, 8'h12);
      start1 = 1'b0; step(1);
      chk("cd0_restart_play", 106, 8'(state1), 8'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
